// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch stage.
package fetch_pkg;

   localparam logic [31:0] FIRST_ADDRESS_DEF = 32'h0000_0000;
   localparam logic [31:0] PC_INC_DEF        = 32'd4;
   localparam logic [31:0] NOP_INSTR         = 32'h0000_0000;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } fetch_state_e;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc_plus4;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of fetched instructions; the head entry is visible with no read latency.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             flush_i,
   input  logic             push_i,
   input  logic             pop_i,
   input  fetch_entry_t     data_i,
   output fetch_entry_t     data_o,
   output logic [CNT_W-1:0] count_o,
   output logic             empty_o,
   output logic             full_o
);

   fetch_entry_t     mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push;
   logic             do_pop;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign count_o = count_q;
   assign data_o  = mem_q[rd_ptr_q];

   // A pop frees a slot in the same cycle, so a full FIFO may still accept a push.
   assign do_pop  = pop_i && !empty_o && !flush_i;
   assign do_push = push_i && !flush_i && (!full_o || do_pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
         end
         if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= data_i;
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, issues credit-limited requests to an in-order memory
// and buffers tagged responses for IF/ID, with stall and redirect handling.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] FIRST_ADDRESS   = FIRST_ADDRESS_DEF,
   parameter logic [31:0] PC_INC          = PC_INC_DEF,
   parameter int          FIFO_DEPTH      = 4,
   parameter int          MAX_OUTSTANDING = 4
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        stall_i,
   input  logic        redirect_valid_i,
   input  logic [31:0] redirect_target_i,
   output logic        imem_req_valid_o,
   input  logic        imem_req_ready_i,
   output logic [31:0] imem_req_addr_o,
   input  logic        imem_resp_valid_i,
   input  logic [31:0] imem_resp_data_i,
   output logic        if_valid_o,
   output logic [31:0] if_instr_o,
   output logic [31:0] if_pc_plus4_o
);

   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

   fetch_state_e     state_q, state_d;
   logic [31:0]      fetch_pc_q, fetch_pc_d;
   logic [31:0]      resp_pc_q, resp_pc_d;
   logic [CNT_W-1:0] outstanding_q, outstanding_d;
   logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

   logic [CNT_W:0]   live_cnt;
   logic             req_valid;
   logic [31:0]      req_addr;
   logic             accept;
   logic             resp_ok;

   logic             fifo_flush;
   logic             fifo_push;
   logic             fifo_pop;
   fetch_entry_t     push_entry;
   fetch_entry_t     fifo_head;
   logic [CNT_W-1:0] fifo_count;
   logic             fifo_empty;
   logic             fifo_full;

   fetch_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .flush_i (fifo_flush),
      .push_i  (fifo_push),
      .pop_i   (fifo_pop),
      .data_i  (push_entry),
      .data_o  (fifo_head),
      .count_o (fifo_count),
      .empty_o (fifo_empty),
      .full_o  (fifo_full)
   );

   // Responses still owed to the FIFO plus buffered entries must leave room for
   // one more, so a push can never overflow.
   always_comb begin
      state_d          = state_q;
      fetch_pc_d       = fetch_pc_q;
      resp_pc_d        = resp_pc_q;
      outstanding_d    = outstanding_q;
      drop_cnt_d       = drop_cnt_q;
      req_valid        = 1'b0;
      req_addr         = fetch_pc_q;
      fifo_flush       = 1'b0;
      fifo_push        = 1'b0;
      push_entry.instr    = imem_resp_data_i;
      push_entry.pc_plus4 = resp_pc_q + PC_INC;
      live_cnt         = {1'b0, outstanding_q - drop_cnt_q} + {1'b0, fifo_count};

      case (state_q)
         IDLE: state_d = RUN;
         RUN: begin
            req_valid = (live_cnt < (CNT_W + 1)'(FIFO_DEPTH)) &&
                        (outstanding_q < CNT_W'(MAX_OUTSTANDING)) &&
                        !fifo_full;
         end
         default: state_d = IDLE;
      endcase

      if (req_valid && redirect_valid_i) begin
         req_addr = redirect_target_i;
      end

      accept        = req_valid && imem_req_ready_i;
      resp_ok       = imem_resp_valid_i && (outstanding_q != '0);
      outstanding_d = outstanding_q + CNT_W'(accept) - CNT_W'(resp_ok);

      // On redirect every older request is in flight to be dropped; only one
      // accepted this cycle (already retargeted) survives.
      if (redirect_valid_i) begin
         fifo_flush = 1'b1;
         resp_pc_d  = redirect_target_i;
         drop_cnt_d = outstanding_q - CNT_W'(resp_ok);
         fetch_pc_d = accept ? (redirect_target_i + PC_INC) : redirect_target_i;
      end else begin
         if (accept) begin
            fetch_pc_d = fetch_pc_q + PC_INC;
         end
         if (resp_ok) begin
            if (drop_cnt_q != '0) begin
               drop_cnt_d = drop_cnt_q - 1'b1;
            end else begin
               fifo_push = 1'b1;
               resp_pc_d = resp_pc_q + PC_INC;
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q       <= IDLE;
         fetch_pc_q    <= FIRST_ADDRESS;
         resp_pc_q     <= FIRST_ADDRESS;
         outstanding_q <= '0;
         drop_cnt_q    <= '0;
      end else begin
         state_q       <= state_d;
         fetch_pc_q    <= fetch_pc_d;
         resp_pc_q     <= resp_pc_d;
         outstanding_q <= outstanding_d;
         drop_cnt_q    <= drop_cnt_d;
      end
   end

   assign fifo_pop         = !fifo_empty && !stall_i;
   assign imem_req_valid_o = req_valid;
   assign imem_req_addr_o  = req_addr;
   assign if_valid_o       = !fifo_empty;
   assign if_instr_o       = fifo_empty ? NOP_INSTR : fifo_head.instr;
   assign if_pc_plus4_o    = fifo_empty ? 32'h0000_0000 : fifo_head.pc_plus4;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with an in-order variable-latency memory model
// and a scoreboard of expected IF/ID entries.
`timescale 1ns/1ps
module tb_fetch_unit;
   import fetch_pkg::*;

   localparam logic [31:0] INC = 32'd4;

   typedef struct {
      logic [31:0] addr;
      int          due;
   } memReq_t;

   logic        clk = 1'b0;
   logic        rstN;
   logic        stall;
   logic        redirectValid;
   logic [31:0] redirectTarget;
   logic        imemReqValid;
   logic        imemReqReady;
   logic [31:0] imemReqAddr;
   logic        imemRespValid;
   logic [31:0] imemRespData;
   logic        ifValid;
   logic [31:0] ifInstr;
   logic [31:0] ifPcPlus4;

   memReq_t      pending[$];
   fetch_entry_t expQ[$];
   int           cyc = 0;
   int           memLatency = 1;
   int           lastDue = 0;
   int           passCount = 0;
   int           checkCount = 0;
   int           acceptTotal = 0;
   int           respTotal = 0;
   logic [31:0]  modelPc = 32'h0;

   always #5 clk = ~clk;

   fetch_unit #(
      .FIRST_ADDRESS   (32'h0000_0000),
      .PC_INC          (INC),
      .FIFO_DEPTH      (4),
      .MAX_OUTSTANDING (4)
   ) dut (
      .clk_i             (clk),
      .rst_ni            (rstN),
      .stall_i           (stall),
      .redirect_valid_i  (redirectValid),
      .redirect_target_i (redirectTarget),
      .imem_req_valid_o  (imemReqValid),
      .imem_req_ready_i  (imemReqReady),
      .imem_req_addr_o   (imemReqAddr),
      .imem_resp_valid_i (imemRespValid),
      .imem_resp_data_i  (imemRespData),
      .if_valid_o        (ifValid),
      .if_instr_o        (ifInstr),
      .if_pc_plus4_o     (ifPcPlus4)
   );

   function automatic logic [31:0] memData(input logic [31:0] a);
      return {a[15:0] ^ 16'h5A3C, ~a[15:0]};
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      assert (observed === expected) passCount++;
      else $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
   endtask

   task automatic checkFlag(input string tag, input logic observed, input logic expected);
      checkCount++;
      assert (observed === expected) passCount++;
      else $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
   endtask

   // Observes the settled cycle: compares the IF/ID head, models redirect and accepts.
   task automatic scoreboardStep();
      fetch_entry_t head;
      fetch_entry_t entry;
      memReq_t      req;
      if (imemRespValid) begin
         assert (respTotal < acceptTotal)
         else $error("[TB] FAIL protoResp: observed response with %0d outstanding expected >0", acceptTotal - respTotal);
         respTotal++;
      end
      if (ifValid) begin
         checkFlag("entryExpected", expQ.size() != 0, 1'b1);
         if (expQ.size() != 0) begin
            head = expQ[0];
            checkOutput("ifInstr", ifInstr, head.instr);
            checkOutput("ifPcPlus4", ifPcPlus4, head.pc_plus4);
            if (!stall && !redirectValid) expQ.delete(0);
         end
      end
      if (redirectValid) begin
         expQ.delete();
         modelPc = redirectTarget;
      end
      if (imemReqValid) checkOutput("reqAddr", imemReqAddr, modelPc);
      if (imemReqValid && imemReqReady) begin
         req.addr = modelPc;
         req.due  = cyc + memLatency;
         if (req.due <= lastDue) req.due = lastDue + 1;
         lastDue = req.due;
         pending.push_back(req);
         acceptTotal++;
         entry.instr    = memData(modelPc);
         entry.pc_plus4 = modelPc + INC;
         expQ.push_back(entry);
         modelPc = modelPc + INC;
      end
   endtask

   task automatic applyStimulus(input logic st, input logic rv, input logic [31:0] rt, input logic rdy);
      stall          = st;
      redirectValid  = rv;
      redirectTarget = rt;
      imemReqReady   = rdy;
      #1;
      scoreboardStep();
   endtask

   task automatic advance();
      @(posedge clk);
      cyc++;
      @(negedge clk);
      imemRespValid = 1'b0;
      imemRespData  = 32'h0;
      if (rstN && pending.size() != 0 && pending[0].due <= cyc) begin
         imemRespValid = 1'b1;
         imemRespData  = memData(pending[0].addr);
         pending.delete(0);
      end
   endtask

   task automatic waitForValid(input string tag, input int budget);
      logic found;
      found = 1'b0;
      for (int i = 0; i < budget; i++) begin
         applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
         if (ifValid) begin
            found = 1'b1;
            break;
         end
         advance();
      end
      checkFlag(tag, found, 1'b1);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed no finish expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [31:0] heldInstr;
      logic [31:0] resumePc;
      rstN = 1'b0;
      stall = 1'b0;
      redirectValid = 1'b0;
      redirectTarget = 32'h0;
      imemReqReady = 1'b1;
      imemRespValid = 1'b0;
      imemRespData = 32'h0;
      heldInstr = 32'h0;
      resumePc = 32'h0;
      #1;
      checkFlag("rstReqValid", imemReqValid, 1'b0);
      checkOutput("rstReqAddr", imemReqAddr, 32'h0);
      checkFlag("rstIfValid", ifValid, 1'b0);
      checkOutput("rstIfInstr", ifInstr, 32'h0);
      checkOutput("rstIfPcPlus4", ifPcPlus4, 32'h0);
      repeat (2) @(negedge clk);
      rstN = 1'b1;

      // Startup with 1-cycle memory
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
      checkFlag("idleNoReq", imemReqValid, 1'b0);
      advance();
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
      checkFlag("req0Valid", imemReqValid, 1'b1);
      checkOutput("req0Addr", imemReqAddr, 32'h0);
      checkFlag("noIfYet0", ifValid, 1'b0);
      advance();
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
      checkOutput("req1Addr", imemReqAddr, 32'h4);
      checkFlag("noIfYet1", ifValid, 1'b0);
      advance();
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
      checkOutput("req2Addr", imemReqAddr, 32'h8);
      checkFlag("firstIfValid", ifValid, 1'b1);
      checkOutput("firstPcPlus4", ifPcPlus4, 32'h4);
      advance();
      for (int i = 0; i < 6; i++) begin
         applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
         checkFlag("streamValid", ifValid, 1'b1);
         advance();
      end

      // Stall fills the FIFO and throttles requests
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
         if (i == 0) heldInstr = expQ[0].instr;
         checkFlag("stallValid", ifValid, 1'b1);
         checkOutput("stallHold", ifInstr, heldInstr);
         if (i == 9) checkFlag("stallNoReq", imemReqValid, 1'b0);
         advance();
      end
      resumePc = modelPc;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
         checkFlag("drainValid", ifValid, 1'b1);
         if (i == 1) begin
            checkFlag("resumeReq", imemReqValid, 1'b1);
            checkOutput("resumeAddr", imemReqAddr, resumePc);
         end
         advance();
      end

      // Redirect with three in flight at latency 3
      memLatency = 3;
      for (int i = 0; i < 30; i++) begin
         applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
         if (pending.size() >= 3) break;
         advance();
      end
      advance();
      applyStimulus(1'b0, 1'b1, 32'h100, 1'b1);
      advance();
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
      checkFlag("postRedirEmpty", ifValid, 1'b0);
      advance();
      waitForValid("redirArrive", 20);
      checkOutput("redirPcPlus4", ifPcPlus4, 32'h104);
      checkOutput("redirInstr", ifInstr, memData(32'h100));
      advance();

      // Redirect during stall with two buffered, then ready held low
      memLatency = 1;
      for (int i = 0; i < 20; i++) begin
         applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
         if (expQ.size() - pending.size() == 2) break;
         advance();
      end
      advance();
      applyStimulus(1'b1, 1'b1, 32'h200, 1'b0);
      checkFlag("preFlushValid", ifValid, 1'b1);
      advance();
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
         checkFlag("flushEmpty", ifValid, 1'b0);
         checkFlag("notReadyReqValid", imemReqValid, 1'b1);
         checkOutput("notReadyAddr", imemReqAddr, 32'h200);
         advance();
      end
      waitForValid("redir2Arrive", 20);
      checkOutput("redir2PcPlus4", ifPcPlus4, 32'h204);
      checkOutput("redir2Instr", ifInstr, memData(32'h200));
      advance();

      // Asynchronous reset mid-stream
      memLatency = 2;
      for (int i = 0; i < 6; i++) begin
         applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
         advance();
      end
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
      checkFlag("preResetValid", ifValid, 1'b1);
      rstN = 1'b0;
      #1;
      checkFlag("asyncIfValid", ifValid, 1'b0);
      checkFlag("asyncReqValid", imemReqValid, 1'b0);
      checkOutput("asyncReqAddr", imemReqAddr, 32'h0);
      pending.delete();
      expQ.delete();
      modelPc = 32'h0;
      acceptTotal = 0;
      respTotal = 0;
      lastDue = 0;
      stall = 1'b0;
      advance();
      advance();
      rstN = 1'b1;
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
      checkFlag("restartIdle", imemReqValid, 1'b0);
      advance();
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
      checkFlag("restartReqValid", imemReqValid, 1'b1);
      checkOutput("restartAddr", imemReqAddr, 32'h0);
      advance();
      waitForValid("restartArrive", 20);
      checkOutput("restartPcPlus4", ifPcPlus4, 32'h4);
      advance();
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
         advance();
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
